// File: rtl/miner_nonce_dispatcher.sv
// miner_nonce_dispatcher: sequences nonce counter, hash core handshake and target compare
module miner_nonce_dispatcher #(
  parameter int NONCE_BITS = 32,
  parameter int HASH_BITS  = 256
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [HASH_BITS-1:0]  target,
  input  logic [NONCE_BITS-1:0] nonce_last,
  input  logic [NONCE_BITS-1:0] nonce_in,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  output logic                  core_valid,
  output logic [NONCE_BITS-1:0] core_nonce,
  input  logic                  core_ready,
  input  logic                  hash_valid,
  input  logic [HASH_BITS-1:0]  hash_in,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [NONCE_BITS-1:0] golden_nonce
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                state_q, state_d;
  logic                  found_q, found_d, exh_q, exh_d;
  logic [NONCE_BITS-1:0] golden_q, golden_d, inflight_q, inflight_d;
  // state and result registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      found_q    <= 1'b0;
      exh_q      <= 1'b0;
      golden_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      found_q    <= found_d;
      exh_q      <= exh_d;
      golden_q   <= golden_d;
      inflight_q <= inflight_d;
    end
  end
  // next-state and Mealy counter controls; abort outranks handshake and hash result
  always_comb begin
    state_d    = state_q;
    found_d    = found_q;
    exh_d      = exh_q;
    golden_d   = golden_q;
    inflight_d = inflight_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (abort && state_q == DONE) begin
          state_d = IDLE;
          found_d = 1'b0;
          exh_d   = 1'b0;
        end else if (start && !abort) begin
          cnt_clear = 1'b1;
          found_d   = 1'b0;
          exh_d     = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          found_d = 1'b0;
          exh_d   = 1'b0;
        end else if (core_ready) begin
          inflight_d = nonce_in;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          found_d = 1'b0;
          exh_d   = 1'b0;
        end else if (hash_valid) begin
          if (hash_in < target) begin
            golden_d = inflight_q;
            found_d  = 1'b1;
            state_d  = DONE;
          end else if (inflight_q == nonce_last) begin
            exh_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_enable = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign core_valid   = state_q == ISSUE;
  assign core_nonce   = nonce_in;
  assign found        = found_q;
  assign exhausted    = exh_q;
  assign golden_nonce = golden_q;
endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// tb_miner_nonce_dispatcher: directed and randomized checks against a search-outcome model
module tb_miner_nonce_dispatcher;
  localparam int NB = 32;
  localparam int HB = 256;
  logic          clk = 1'b0, n_rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic          core_ready = 1'b0, hash_valid = 1'b0;
  logic [HB-1:0] target = '0, hash_in = '0;
  logic [NB-1:0] nonce_last = '0, cnt_q;
  logic          cnt_clear, cnt_enable, core_valid, busy, found, exhausted;
  logic [NB-1:0] core_nonce, golden_nonce;
  logic [HB-1:0] hashes [16];
  logic [NB-1:0] exp_golden = '0;
  int            checks = 0, failures = 0;

  miner_nonce_dispatcher #(.NONCE_BITS(NB), .HASH_BITS(HB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .target(target),
    .nonce_last(nonce_last), .nonce_in(cnt_q), .cnt_clear(cnt_clear),
    .cnt_enable(cnt_enable), .core_valid(core_valid), .core_nonce(core_nonce),
    .core_ready(core_ready), .hash_valid(hash_valid), .hash_in(hash_in),
    .busy(busy), .found(found), .exhausted(exhausted), .golden_nonce(golden_nonce)
  );

  always #5 clk = ~clk;

  // upstream nonce counter, step 1
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else if (cnt_clear) cnt_q <= '0;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;

  task automatic chk(input string tag, input logic [HB-1:0] obs, input logic [HB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HB-1:0] rand_hash();
    logic [HB-1:0] h;
    for (int i = 0; i < HB / 32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_exh"}, exhausted, 0);
    chk({tag, "_golden"}, golden_nonce, 0);
    chk({tag, "_valid"}, core_valid, 0);
    chk({tag, "_nonce"}, core_nonce, 0);
    chk({tag, "_clear"}, cnt_clear, 0);
    chk({tag, "_enable"}, cnt_enable, 0);
  endtask

  task automatic idle_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("idle_clear", cnt_clear, 0);
      chk("idle_enable", cnt_enable, 0);
      chk("idle_valid", core_valid, 0);
    end
  endtask

  // full search with a 3-cycle hash core; outcome compared with a scan of the hash table
  task automatic run_search(input int last, input int rdy_pct);
    int cd, cyc, n_en, n_hs, exp_en, exp_hs;
    bit exp_f, exp_e;
    logic [NB-1:0] pn;
    nonce_last = NB'(last);
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("start_clear", cnt_clear, 1);
    @(negedge clk);
    start = 1'b0;
    chk("start_found", found, 0);
    chk("start_exh", exhausted, 0);
    chk("start_valid", core_valid, 1);
    chk("start_nonce", core_nonce, 0);
    chk("golden_hold", golden_nonce, exp_golden);
    cd = -1; cyc = 0; n_en = 0; n_hs = 0; pn = '0;
    while (busy && cyc < 3000) begin
      hash_valid = 1'b0;
      if (cd == 0) begin
        hash_valid = 1'b1;
        hash_in    = hashes[pn[3:0]];
        cd         = -1;
      end else if (cd > 0) cd--;
      core_ready = $urandom_range(0, 99) < rdy_pct;
      #1;
      if (cnt_enable) n_en++;
      chk("no_overlap", core_valid && cd != -1, 0);
      if (core_valid && core_ready) begin
        chk("issue_nonce", core_nonce, NB'(n_hs));
        n_hs++;
        pn = core_nonce;
        cd = 2;
      end
      @(negedge clk);
      cyc++;
    end
    hash_valid = 1'b0;
    core_ready = 1'b0;
    chk("search_timeout", cyc < 3000, 1);
    exp_f = 0; exp_e = 1; exp_en = last; exp_hs = last + 1;
    for (int i = 0; i <= last; i++)
      if (hashes[i] < target) begin
        exp_f = 1; exp_e = 0; exp_en = i; exp_hs = i + 1;
        exp_golden = NB'(i);
        break;
      end
    chk("res_found", found, exp_f);
    chk("res_exh", exhausted, exp_e);
    chk("res_golden", golden_nonce, exp_golden);
    chk("res_enables", n_en, exp_en);
    chk("res_issues", n_hs, exp_hs);
    chk("res_busy", busy, 0);
  endtask

  initial begin
    #1;
    chk_all_zero("rst0");
    @(negedge clk);
    n_rst = 1'b1;
    idle_checks(3);

    target = HB'(32'h100);
    for (int i = 0; i < 16; i++) hashes[i] = HB'(32'h1000);
    hashes[0] = HB'(32'h200);
    hashes[1] = HB'(32'h300);
    hashes[2] = HB'(32'h0FF);
    run_search(15, 100);

    for (int i = 0; i < 16; i++) hashes[i] = HB'(32'h100 + i * 7);
    hashes[1] = target;
    run_search(3, 100);

    @(negedge clk);
    start = 1'b1;
    core_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", core_valid, 1);
      chk("bp_nonce", core_nonce, 0);
      chk("bp_enable", cnt_enable, 0);
      @(negedge clk);
    end
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    chk("wait_valid", core_valid, 0);
    chk("wait_busy", busy, 1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_enable", cnt_enable, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    @(negedge clk);
    hash_valid = 1'b1;
    hash_in = '0;
    #1;
    chk("stray_enable", cnt_enable, 0);
    @(negedge clk);
    hash_valid = 1'b0;
    chk("stray_found", found, 0);
    chk("stray_busy", busy, 0);
    chk("stray_valid", core_valid, 0);
    chk("stray_golden", golden_nonce, exp_golden);

    for (int r = 0; r < 12; r++) begin
      target = rand_hash();
      target[HB-1 -: 32] = $urandom_range(0, 32'h2000_0000);
      for (int i = 0; i < 16; i++) hashes[i] = rand_hash();
      hashes[$urandom_range(0, 15)] = target;
      run_search($urandom_range(0, 15), 70);
    end

    target = HB'(32'h100);
    for (int i = 0; i < 16; i++) hashes[i] = HB'(32'h5000);
    hashes[5] = HB'(32'h1);
    run_search(15, 100);
    @(negedge clk);
    start = 1'b1;
    core_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_ready = 1'b0;
    chk("prerst_busy", busy, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    exp_golden = '0;
    @(negedge clk);
    n_rst = 1'b1;
    idle_checks(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/miner_nonce_dispatcher.md
# miner_nonce_dispatcher

Sequencing stage directly downstream of the miner nonce counter. Owns the counter's `clear`/`count_enable` inputs, issues each nonce to the hash core over a valid/ready handshake, and waits for the resulting hash. It compares that hash against the difficulty target and either captures the golden nonce or advances the counter. It stops when a golden nonce is found, the nonce range is exhausted, or software aborts.

## Interface
- `NONCE_BITS`, 32, nonce width; matches counter `NUM_CNT_BITS`
- `HASH_BITS`, 256, hash and target width
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins a search from nonce 0
- `abort`  in  1  single-cycle pulse; cancels the search in progress
- `target`  in  HASH_BITS  difficulty target; stable while busy
- `nonce_last`  in  NONCE_BITS  final nonce of the range; stable while busy
- `nonce_in`  in  NONCE_BITS  counter `count_out`
- `cnt_clear`  out  1  to counter `clear`
- `cnt_enable`  out  1  to counter `count_enable`
- `core_valid`  out  1  nonce offered to hash core
- `core_nonce`  out  NONCE_BITS  nonce offered; equals `nonce_in`
- `core_ready`  in  1  hash core accepts a nonce
- `hash_valid`  in  1  single-cycle pulse; `hash_in` is valid
- `hash_in`  in  HASH_BITS  hash result for the in-flight nonce
- `busy`  out  1  search in progress
- `found`  out  1  golden nonce captured; sticky
- `exhausted`  out  1  range finished with no golden nonce; sticky
- `golden_nonce`  out  NONCE_BITS  captured winning nonce

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE. Reset enters IDLE. Reset clears `found`, `exhausted`, `golden_nonce`, and the in-flight register to 0.
- IDLE or DONE with `start`=1:
  - Assert `cnt_clear` combinationally that cycle.
  - Clear `found` and `exhausted`.
  - Go to ISSUE.
- ISSUE:
  - Assert `core_valid`; `core_nonce` = `nonce_in`.
  - On `core_valid & core_ready`, latch `nonce_in` into the in-flight register and go to WAIT.
  - `core_nonce` stays stable while `core_ready`=0, because the counter is never enabled in ISSUE.
- WAIT, on `hash_valid`=1:
  - If `hash_in < target` (unsigned, strict): `golden_nonce` ← in-flight, `found` ← 1, go to DONE.
  - Else if in-flight == `nonce_last`: `exhausted` ← 1, go to DONE.
  - Else: assert `cnt_enable` combinationally that cycle and go to ISSUE. The counter advances by its step on that edge.
- Golden takes priority over exhausted. A hit on `nonce_last` reports `found` only.
- `hash_valid` is ignored in IDLE, ISSUE, and DONE.
- `abort` in ISSUE, WAIT, or DONE:
  - Go to IDLE next cycle.
  - Clear `found` and `exhausted`; `golden_nonce` is retained.
  - No `cnt_enable` that cycle.
  - `abort` has priority over `hash_valid` and the handshake in the same cycle.
- `start` while busy is ignored. Simultaneous `start` and `abort` in IDLE or DONE: `abort` wins and the FSM stays in or moves to IDLE.
- `busy` = state ∈ {ISSUE, WAIT}. `core_valid` = state == ISSUE. Both are decoded from the state register only.
- At most one nonce is in flight. A second `core_valid` never precedes the `hash_valid` for the previous nonce.

## Timing
- `busy`, `core_valid`, `found`, `exhausted`, `golden_nonce`: registered, glitch-free.
- `cnt_clear`, `cnt_enable`: Mealy outputs, high for exactly one cycle.
- Start latency: `start` at cycle 0 → `core_valid`=1 with `core_nonce`=0 at cycle 1.
- Handshake at cycle k → WAIT from cycle k+1; `core_valid`=0 at k+1.
- Non-golden `hash_valid` at cycle m → `core_valid`=1 at m+1 with `core_nonce` = previous nonce + counter step.
- Golden or exhausted `hash_valid` at cycle m → `found` or `exhausted` =1 and `busy`=0 at m+1.
- Asynchronous `n_rst` mid-search returns to IDLE immediately. The hash core is responsible for discarding its own job.

## Test plan
- Reset check: assert `n_rst`=0 mid-WAIT → all outputs 0 and FSM in IDLE before the next edge; release, idle 3 cycles → `cnt_clear`=0, `cnt_enable`=0, `core_valid`=0.
- Golden search:
  - Setup: `core_ready`=1, `hash_valid` 3 cycles after each handshake, `target`=0x100, `nonce_last`=15.
  - Stimulus: hashes 0x200 and 0x300 for nonces 0 and 1, then 0x0FF for nonce 2.
  - Required response: `found`=1, `golden_nonce`=2, exactly 2 `cnt_enable` pulses.
- Exhaustion:
  - Setup: `nonce_last`=3, every hash ≥ `target`.
  - Required response: `exhausted`=1 after nonce 3's result, `found`=0, 3 `cnt_enable` pulses, no 5th `core_valid`.
- Backpressure and strict compare:
  - Stimulus: `core_ready`=0 for 5 cycles in ISSUE; required response: `core_valid`=1 throughout, `core_nonce` constant, `cnt_enable`=0.
  - Stimulus: `hash_in`==`target`; required response: treated as non-golden.
- Abort with stray result:
  - Stimulus: `abort` in WAIT, then `hash_valid` with `hash_in`=0 two cycles later.
  - Required response: IDLE, `found`=0, `busy`=0, no `cnt_enable`.
- Restart from DONE:
  - Stimulus: after `found`=1, pulse `start`.
  - Required response: `cnt_clear` pulse, `found`=0 next cycle, `core_nonce`=0, `golden_nonce` retained until the next capture.
